// File: rtl/twilight_fade_sequencer.sv
// Day/night background fade sequencer: holds, ramps and override commands,
// all advancing only on frame boundaries so the blend never changes mid-frame.
module twilight_fade_sequencer #(
    parameter int unsigned HOLD_FRAMES     = 120,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned STEP            = 1
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic       cmd_day,
    output logic       cmd_ready,
    output logic [7:0] fade_level,
    output logic [1:0] phase,
    output logic       phase_change
);

    typedef enum logic [1:0] {
        NIGHT_HOLD = 2'b00,
        DAWN       = 2'b01,
        DAY_HOLD   = 2'b10,
        DUSK       = 2'b11
    } phase_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [8:0]  STEP_9    = 9'(STEP);

    phase_t      state;
    logic [7:0]  level;
    logic [15:0] hold_cnt;
    logic [7:0]  div_cnt;
    logic        pending;
    logic        pending_day;
    logic        change;

    logic [8:0]  level_up;
    logic [8:0]  level_dn;
    logic        cmd_accept;

    // Bit 8 of level_dn is the borrow: set whenever STEP exceeds the level.
    always_comb begin
        level_up   = {1'b0, level} + STEP_9;
        level_dn   = {1'b0, level} - STEP_9;
        cmd_accept = cmd_valid && !pending;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state       <= NIGHT_HOLD;
            level       <= '0;
            hold_cnt    <= '0;
            div_cnt     <= '0;
            pending     <= 1'b0;
            pending_day <= 1'b0;
            change      <= 1'b0;
        end else begin
            change <= 1'b0;
            if (cmd_accept) begin
                pending     <= 1'b1;
                pending_day <= cmd_day;
            end
            if (frame_start) begin
                // A command latched on this same edge is not yet pending, so it waits a frame.
                if (pending) begin
                    pending  <= 1'b0;
                    hold_cnt <= '0;
                    div_cnt  <= '0;
                    if (pending_day) begin
                        level  <= '1;
                        state  <= DAY_HOLD;
                        change <= (state != DAY_HOLD);
                    end else begin
                        level  <= '0;
                        state  <= NIGHT_HOLD;
                        change <= (state != NIGHT_HOLD);
                    end
                end else if (enable) begin
                    unique case (state)
                        NIGHT_HOLD, DAY_HOLD: begin
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= '0;
                                div_cnt  <= '0;
                                state    <= (state == NIGHT_HOLD) ? DAWN : DUSK;
                                change   <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 16'd1;
                            end
                        end
                        DAWN: begin
                            if (div_cnt == DIV_LAST) begin
                                div_cnt <= '0;
                                if (level_up >= 9'd255) begin
                                    level    <= '1;
                                    hold_cnt <= '0;
                                    state    <= DAY_HOLD;
                                    change   <= 1'b1;
                                end else begin
                                    level <= level_up[7:0];
                                end
                            end else begin
                                div_cnt <= div_cnt + 8'd1;
                            end
                        end
                        DUSK: begin
                            if (div_cnt == DIV_LAST) begin
                                div_cnt <= '0;
                                if (level_dn[8] || level_dn == 9'd0) begin
                                    level    <= '0;
                                    hold_cnt <= '0;
                                    state    <= NIGHT_HOLD;
                                    change   <= 1'b1;
                                end else begin
                                    level <= level_dn[7:0];
                                end
                            end else begin
                                div_cnt <= div_cnt + 8'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign cmd_ready    = !pending;
    assign fade_level   = level;
    assign phase        = state;
    assign phase_change = change;

endmodule

// File: tb/tb_twilight_fade_sequencer.sv
// Directed bench for twilight_fade_sequencer: three parameterisations share one
// stimulus bus; each scenario resets all of them and checks the relevant instance.
module tb_twilight_fade_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic enable = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_day = 1'b0;

    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] fade_a, fade_b, fade_c;
    logic [1:0] phase_a, phase_b, phase_c;
    logic       pc_a, pc_b, pc_c;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    twilight_fade_sequencer #(.HOLD_FRAMES(2), .FRAMES_PER_STEP(1), .STEP(64)) dut_a (
        .clk_pix(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_day(cmd_day), .cmd_ready(rdy_a),
        .fade_level(fade_a), .phase(phase_a), .phase_change(pc_a)
    );

    twilight_fade_sequencer #(.HOLD_FRAMES(2), .FRAMES_PER_STEP(3), .STEP(1)) dut_b (
        .clk_pix(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_day(cmd_day), .cmd_ready(rdy_b),
        .fade_level(fade_b), .phase(phase_b), .phase_change(pc_b)
    );

    twilight_fade_sequencer #(.HOLD_FRAMES(2), .FRAMES_PER_STEP(1), .STEP(25)) dut_c (
        .clk_pix(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_day(cmd_day), .cmd_ready(rdy_c),
        .fade_level(fade_c), .phase(phase_c), .phase_change(pc_c)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle frame pulse; back-to-back calls give consecutive-cycle frames.
    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_b[6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        tick();
        tick();

        // Full day/night cycle, STEP=64
        do_reset();
        check("rst_phase", phase_a, 0);
        check("rst_fade", fade_a, 0);
        check("rst_ready", rdy_a, 1);
        check("rst_pc", pc_a, 0);
        frame();
        check("night1_phase", phase_a, 0);
        check("night1_pc", pc_a, 0);
        frame();
        check("dawn_enter_phase", phase_a, 1);
        check("dawn_enter_pc", pc_a, 1);
        tick();
        check("dawn_pc_drop", pc_a, 0);
        frame(); check("dawn_64", fade_a, 64);
        frame(); check("dawn_128", fade_a, 128);
        frame(); check("dawn_192", fade_a, 192);
        check("dawn_192_phase", phase_a, 1);
        frame();
        check("dawn_sat_255", fade_a, 255);
        check("day_enter_phase", phase_a, 2);
        check("day_enter_pc", pc_a, 1);
        frame();
        check("day1_phase", phase_a, 2);
        check("day1_pc", pc_a, 0);
        frame();
        check("dusk_enter_phase", phase_a, 3);
        check("dusk_enter_pc", pc_a, 1);
        check("dusk_enter_fade", fade_a, 255);
        frame(); check("dusk_191", fade_a, 191);
        frame(); check("dusk_127", fade_a, 127);
        frame(); check("dusk_63", fade_a, 63);
        frame();
        check("dusk_floor_0", fade_a, 0);
        check("night_enter_phase", phase_a, 0);
        check("night_enter_pc", pc_a, 1);

        // Mid-frame day override from NIGHT_HOLD
        cmd_valid = 1'b1; cmd_day = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("ovr_ready_low", rdy_a, 0);
        check("ovr_wait_phase", phase_a, 0);
        tick();
        check("ovr_ready_held", rdy_a, 0);
        frame();
        check("ovr_day_fade", fade_a, 255);
        check("ovr_day_phase", phase_a, 2);
        check("ovr_day_pc", pc_a, 1);
        check("ovr_ready_back", rdy_a, 1);
        tick();
        check("ovr_pc_once", pc_a, 0);

        // Override onto the current phase: no phase_change
        cmd_valid = 1'b1; cmd_day = 1'b1;
        tick();
        cmd_valid = 1'b0;
        frame();
        check("ovr_same_phase", phase_a, 2);
        check("ovr_same_pc", pc_a, 0);

        // Night override applies while frozen
        enable = 1'b0;
        cmd_valid = 1'b1; cmd_day = 1'b0;
        tick();
        cmd_valid = 1'b0;
        frame();
        check("ovr_frozen_phase", phase_a, 0);
        check("ovr_frozen_fade", fade_a, 0);
        check("ovr_frozen_pc", pc_a, 1);
        frame();
        check("frozen_night_phase", phase_a, 0);
        enable = 1'b1;

        // Command coincident with frame_start waits one frame, then beats sequencing
        cmd_valid = 1'b1; cmd_day = 1'b1; frame_start = 1'b1;
        tick();
        cmd_valid = 1'b0; frame_start = 1'b0;
        check("coinc_phase", phase_a, 0);
        check("coinc_fade", fade_a, 0);
        check("coinc_ready", rdy_a, 0);
        frame();
        check("coinc_apply_phase", phase_a, 2);
        check("coinc_apply_fade", fade_a, 255);

        // Reset beats simultaneous frame_start and cmd_valid
        rst = 1'b1; frame_start = 1'b1; cmd_valid = 1'b1; cmd_day = 1'b1;
        tick();
        rst = 1'b0; frame_start = 1'b0; cmd_valid = 1'b0;
        check("rst_prio_phase", phase_a, 0);
        check("rst_prio_fade", fade_a, 0);
        check("rst_prio_ready", rdy_a, 1);
        check("rst_prio_pc", pc_a, 0);
        frame();
        check("rst_prio_after_phase", phase_a, 0);
        check("rst_prio_after_fade", fade_a, 0);

        // Divider: FRAMES_PER_STEP=3, STEP=1
        do_reset();
        frames(2);
        check("div_dawn_phase", phase_b, 1);
        for (int i = 0; i < 6; i++) begin
            frame();
            check($sformatf("div_fade_%0d", i), fade_b, exp_b[i]);
        end

        // Freeze at 100 then reset mid-dusk with a pending command, STEP=25
        do_reset();
        frames(6);
        check("frz_pre_fade", fade_c, 100);
        check("frz_pre_phase", phase_c, 1);
        enable = 1'b0;
        frames(10);
        check("frz_fade", fade_c, 100);
        check("frz_phase", phase_c, 1);
        check("frz_pc", pc_c, 0);
        enable = 1'b1;
        frame();
        check("frz_resume", fade_c, 125);
        frames(5);
        check("c_dawn_250", fade_c, 250);
        frame();
        check("c_day_fade", fade_c, 255);
        check("c_day_phase", phase_c, 2);
        frames(2);
        check("c_dusk_phase", phase_c, 3);
        frames(7);
        check("c_dusk_80", fade_c, 80);
        check("c_dusk_80_phase", phase_c, 3);
        cmd_valid = 1'b1; cmd_day = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("c_pending_ready", rdy_c, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c_rst_fade", fade_c, 0);
        check("c_rst_phase", phase_c, 0);
        check("c_rst_ready", rdy_c, 1);
        frame();
        check("c_no_ovr_fade", fade_c, 0);
        check("c_no_ovr_phase", phase_c, 0);
        check("c_no_ovr_pc", pc_c, 0);
        frame();
        check("c_seq_phase", phase_c, 1);
        check("c_seq_pc", pc_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
